// File: rtl/pipe_control_unit_pkg.sv
// Shared opcode, control-bundle and FSM definitions for the pipelined control unit.
// Bundle bit order (MSB first): {branch, MemRead, MemtoReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite, WB[1:0]}.
package pipe_control_unit_pkg;

    localparam int CTRL_W      = 10;
    localparam int BIT_MEMREAD = 8;

    localparam logic [4:0] OPCODE_LOAD   = 5'b00000;
    localparam logic [4:0] OPCODE_ARITHI = 5'b00100;
    localparam logic [4:0] OPCODE_AUIPC  = 5'b00101;
    localparam logic [4:0] OPCODE_STORE  = 5'b01000;
    localparam logic [4:0] OPCODE_R      = 5'b01100;
    localparam logic [4:0] OPCODE_LUI    = 5'b01101;
    localparam logic [4:0] OPCODE_BRANCH = 5'b11000;
    localparam logic [4:0] OPCODE_JALR   = 5'b11001;
    localparam logic [4:0] OPCODE_JAL    = 5'b11011;
    localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;

    localparam logic [CTRL_W-1:0] CTRL_R      = 10'b0001000100;
    localparam logic [CTRL_W-1:0] CTRL_LOAD   = 10'b0110001100;
    localparam logic [CTRL_W-1:0] CTRL_STORE  = 10'b0000011000;
    localparam logic [CTRL_W-1:0] CTRL_BRANCH = 10'b1000100000;
    localparam logic [CTRL_W-1:0] CTRL_ARITHI = 10'b0001101100;
    localparam logic [CTRL_W-1:0] CTRL_LUI    = 10'b0000000111;
    localparam logic [CTRL_W-1:0] CTRL_AUIPC  = 10'b0000000110;
    localparam logic [CTRL_W-1:0] CTRL_JAL    = 10'b1000000101;
    localparam logic [CTRL_W-1:0] CTRL_JALR   = 10'b1000001101;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_control_unit_if.sv
// Bundle between IF/ID, the control unit and the datapath stage registers.
// slave: control unit side (ID fields in, hazards/stage control out); master: the surrounding core.
interface pipe_control_unit_if #(
    parameter int OPC_W = 5,
    parameter int RA_W  = 5
) ();
    import pipe_control_unit_pkg::*;

    logic              id_valid;
    logic [OPC_W-1:0]  id_opcode;
    logic [RA_W-1:0]   id_rs1;
    logic [RA_W-1:0]   id_rs2;
    logic [RA_W-1:0]   id_rd;
    logic              ex_branch_taken;
    logic              stall_o;
    logic              flush_o;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CTRL_W-1:0] mem_ctrl;
    logic [CTRL_W-1:0] wb_ctrl;
    logic [RA_W-1:0]   ex_rd;
    logic [RA_W-1:0]   mem_rd;
    logic [RA_W-1:0]   wb_rd;
    logic              illegal_o;
    logic              halted;

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_branch_taken,
        output stall_o, flush_o, ex_ctrl, mem_ctrl, wb_ctrl,
        output ex_rd, mem_rd, wb_rd, illegal_o, halted
    );

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_branch_taken,
        input  stall_o, flush_o, ex_ctrl, mem_ctrl, wb_ctrl,
        input  ex_rd, mem_rd, wb_rd, illegal_o, halted
    );
endinterface

// File: rtl/pipe_control_unit_ctrl_decode.sv
// Pure combinational opcode decode: control bundle, illegal flag, rs1/rs2 usage.
// Ports: opcode in; ctrl, illegal, uses_rs1, uses_rs2 out.
module pipe_control_unit_ctrl_decode
    import pipe_control_unit_pkg::*;
#(
    parameter int OPC_W = 5
) (
    input  logic [OPC_W-1:0]  opcode,
    output logic [CTRL_W-1:0] ctrl,
    output logic              illegal,
    output logic              uses_rs1,
    output logic              uses_rs2
);

    always_comb begin
        ctrl     = '0;
        illegal  = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OPCODE_R: begin
                ctrl     = CTRL_R;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPCODE_LOAD: begin
                ctrl     = CTRL_LOAD;
                uses_rs1 = 1'b1;
            end
            OPCODE_STORE: begin
                ctrl     = CTRL_STORE;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPCODE_BRANCH: begin
                ctrl     = CTRL_BRANCH;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPCODE_ARITHI: begin
                ctrl     = CTRL_ARITHI;
                uses_rs1 = 1'b1;
            end
            OPCODE_LUI:    ctrl = CTRL_LUI;
            OPCODE_AUIPC:  ctrl = CTRL_AUIPC;
            OPCODE_JAL:    ctrl = CTRL_JAL;
            OPCODE_JALR: begin
                ctrl     = CTRL_JALR;
                uses_rs1 = 1'b1;
            end
            OPCODE_SYSTEM: ctrl = '0;
            default:       illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined control unit: ID decode, ID/EX->EX/MEM->MEM/WB control and rd, hazards, halt FSM.
// Ports: clk, rst (sync, active-high); bus (slave) carries ID fields, stall/flush, stage outputs.
module pipe_control_unit
    import pipe_control_unit_pkg::*;
#(
    parameter int OPC_W        = 5,
    parameter int RA_W         = 5,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst,
    pipe_control_unit_if.slave bus
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_illegal;
    logic              uses_rs1;
    logic              uses_rs2;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [CTRL_W-1:0] mem_ctrl_q, mem_ctrl_d;
    logic [CTRL_W-1:0] wb_ctrl_q, wb_ctrl_d;
    logic [RA_W-1:0]   ex_rd_q, ex_rd_d;
    logic [RA_W-1:0]   mem_rd_q, mem_rd_d;
    logic [RA_W-1:0]   wb_rd_q, wb_rd_d;
    logic              illegal_q, illegal_d;

    logic run;
    logic flush;
    logic load_use;
    logic bubble;
    logic stall;

    pipe_control_unit_ctrl_decode #(
        .OPC_W (OPC_W)
    ) u_decode (
        .opcode   (bus.id_opcode),
        .ctrl     (dec_ctrl),
        .illegal  (dec_illegal),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2)
    );

    always_comb begin
        run   = (state_q == ST_RUN);
        // Redirects are only honoured while running; a drain ignores them.
        flush = run & bus.ex_branch_taken;

        load_use = bus.id_valid & ex_ctrl_q[BIT_MEMREAD] & (ex_rd_q != '0)
                 & ((uses_rs1 & (ex_rd_q == bus.id_rs1))
                  | (uses_rs2 & (ex_rd_q == bus.id_rs2)));

        stall  = run ? (load_use & ~flush) : 1'b1;
        bubble = ~run | flush | load_use | ~bus.id_valid | dec_illegal;

        ex_ctrl_d  = bubble ? '0 : dec_ctrl;
        ex_rd_d    = bubble ? '0 : bus.id_rd;
        mem_ctrl_d = ex_ctrl_q;
        mem_rd_d   = ex_rd_q;
        wb_ctrl_d  = mem_ctrl_q;
        wb_rd_d    = mem_rd_q;
        illegal_d  = run & bus.id_valid & dec_illegal & ~flush;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (bus.id_valid & (bus.id_opcode == OPCODE_SYSTEM) & ~flush) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
                    state_d = ST_HALT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            ex_ctrl_q  <= '0;
            mem_ctrl_q <= '0;
            wb_ctrl_q  <= '0;
            ex_rd_q    <= '0;
            mem_rd_q   <= '0;
            wb_rd_q    <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ex_ctrl_q  <= ex_ctrl_d;
            mem_ctrl_q <= mem_ctrl_d;
            wb_ctrl_q  <= wb_ctrl_d;
            ex_rd_q    <= ex_rd_d;
            mem_rd_q   <= mem_rd_d;
            wb_rd_q    <= wb_rd_d;
            illegal_q  <= illegal_d;
        end
    end

    assign bus.stall_o   = stall;
    assign bus.flush_o   = flush;
    assign bus.ex_ctrl   = ex_ctrl_q;
    assign bus.mem_ctrl  = mem_ctrl_q;
    assign bus.wb_ctrl   = wb_ctrl_q;
    assign bus.ex_rd     = ex_rd_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.illegal_o = illegal_q;
    assign bus.halted    = (state_q == ST_HALT);

endmodule
